// File: rtl/timer_pkg.sv
// Shared types and defaults for the countdown timer block.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } timer_state_t;

  localparam int unsigned TIMER_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/sticky_flag.sv
// Synchronous set/clear flag; set wins over clear, sync active-high reset.
module sticky_flag (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic clear,
  output logic flag
);

  always_ff @(posedge clk) begin
    if (reset)      flag <= 1'b0;
    else if (set)   flag <= 1'b1;
    else if (clear) flag <= 1'b0;
  end

endmodule

// File: rtl/countdown_timer_underflow.sv
// Loadable down-counter with one-shot/auto-reload modes, sticky underflow flag
// and a one-cycle terminal-count pulse.
module countdown_timer_underflow
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             underflow_clr,
  output logic [WIDTH-1:0] counter_out,
  output logic             underflow_out,
  output logic             tc_pulse,
  output logic             busy
);

  timer_state_t     state, state_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic [WIDTH-1:0] count_next;
  logic             tc_next;
  logic             uf_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      counter_out <= '0;
      reload_reg  <= '0;
      tc_pulse    <= 1'b0;
    end else begin
      state       <= state_next;
      counter_out <= count_next;
      reload_reg  <= reload_next;
      tc_pulse    <= tc_next;
    end
  end

  // Load pre-empts any event on the same edge, so no pulse and no flag set.
  always_comb begin
    state_next  = state;
    count_next  = counter_out;
    reload_next = reload_reg;
    tc_next     = 1'b0;
    uf_set      = 1'b0;
    if (load) begin
      count_next  = load_value;
      reload_next = load_value;
      state_next  = (load_value != '0) ? RUN : IDLE;
    end else if (state == RUN && enable) begin
      if (counter_out != '0) begin
        count_next = counter_out - 1'b1;
      end else begin
        tc_next = 1'b1;
        uf_set  = 1'b1;
        if (auto_reload) count_next = reload_reg;
        else             state_next = EXPIRED;
      end
    end
  end

  sticky_flag u_underflow_flag (
    .clk   (clk),
    .reset (reset),
    .set   (uf_set),
    .clear (underflow_clr),
    .flag  (underflow_out)
  );

  assign busy = (state == RUN);

endmodule
